aurora_axi_tx_arb: RTL and testbench

Packet-level round-robin arbiter and registered multiplexer that shares the single Aurora TX AXI-Stream channel among ETHCOUNT Ethernet-side sources. It grants one source at a time, holds the grant until that source's tlast beat is accepted, and presents the selected beats on a fully back-pressured output register. It replaces free-running select-driven muxing: the grant index is exported as axis_s_sel for status and debug.

---
 rtl/aurora_axi_tx_arb.sv | 144 ++++++++++++++
 tb/tb_aurora_axi_tx_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_axi_tx_arb.sv
// Packet-level round-robin arbiter sharing the Aurora TX AXI-Stream channel among
// ETHCOUNT sources; the grant is held until the granted source's tlast beat is accepted.
module aurora_axi_tx_arb #(
    parameter int ETHCOUNT = 4,
    parameter int SIM      = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    output logic [ETHCOUNT-1:0]    axis_s_tready,
    input  logic [ETHCOUNT*32-1:0] axis_s_tdata,
    input  logic [ETHCOUNT*4-1:0]  axis_s_tkeep,
    input  logic [ETHCOUNT-1:0]    axis_s_tvalid,
    input  logic [ETHCOUNT-1:0]    axis_s_tlast,
    input  logic                   axis_m_tready,
    output logic [31:0]            axis_m_tdata,
    output logic [3:0]             axis_m_tkeep,
    output logic                   axis_m_tvalid,
    output logic                   axis_m_tlast,
    output logic [2:0]             axis_s_sel,
    output logic                   arb_busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t      state_r;
    logic [2:0]  ptr_r;
    logic [2:0]  grant_r;
    logic [31:0] m_tdata_r;
    logic [3:0]  m_tkeep_r;
    logic        m_tvalid_r;
    logic        m_tlast_r;

    logic [2:0]  winner_s;
    logic        found_s;
    logic        cand_s;
    logic [31:0] sel_data_s;
    logic [3:0]  sel_keep_s;
    logic        sel_last_s;
    logic        sel_valid_s;
    logic        sel_hit_s;
    logic        out_free_s;
    logic        src_hs_s;
    logic [ETHCOUNT-1:0] tready_s;

    // SIM is carried for interface compatibility only; it has no effect here.
    if (SIM != 0) begin : g_sim_flag
    end

    // Round-robin search: first requester at or above ptr, wrapping to 0.
    always_comb begin
        winner_s = 3'd0;
        found_s  = 1'b0;
        cand_s   = 1'b0;
        for (int k = 0; k < ETHCOUNT; k++) begin
            for (int i = 0; i < ETHCOUNT; i++) begin
                cand_s   = axis_s_tvalid[i] && !found_s && (i == ((int'(ptr_r) + k) % ETHCOUNT));
                winner_s = cand_s ? 3'(i) : winner_s;
                found_s  = found_s | cand_s;
            end
        end
    end

    // Beat multiplexer selecting the granted source.
    always_comb begin
        sel_data_s  = 32'd0;
        sel_keep_s  = 4'd0;
        sel_last_s  = 1'b0;
        sel_valid_s = 1'b0;
        sel_hit_s   = 1'b0;
        for (int i = 0; i < ETHCOUNT; i++) begin
            sel_hit_s   = (grant_r == 3'(i));
            sel_data_s  = sel_hit_s ? axis_s_tdata[i*32 +: 32] : sel_data_s;
            sel_keep_s  = sel_hit_s ? axis_s_tkeep[i*4 +: 4]   : sel_keep_s;
            sel_last_s  = sel_hit_s ? axis_s_tlast[i]          : sel_last_s;
            sel_valid_s = sel_hit_s ? axis_s_tvalid[i]         : sel_valid_s;
        end
    end

    // Source ready depends only on state, grant and output-register occupancy.
    always_comb begin
        tready_s   = '0;
        out_free_s = !m_tvalid_r || axis_m_tready;
        for (int i = 0; i < ETHCOUNT; i++) begin
            tready_s[i] = (state_r == ST_PKT) && (grant_r == 3'(i)) && out_free_s;
        end
        src_hs_s = (state_r == ST_PKT) && sel_valid_s && out_free_s;
    end

    // Arbitration state machine; grant is held through source bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            ptr_r   <= 3'd0;
            grant_r <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r <= winner_s;
                        state_r <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (src_hs_s && sel_last_s) begin
                        ptr_r   <= (grant_r == 3'(ETHCOUNT - 1)) ? 3'd0 : grant_r + 3'd1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: a load wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_tdata_r  <= 32'd0;
            m_tkeep_r  <= 4'd0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
        end else if (src_hs_s) begin
            m_tdata_r  <= sel_data_s;
            m_tkeep_r  <= sel_keep_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= sel_last_s;
        end else if (m_tvalid_r && axis_m_tready) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign axis_s_tready = tready_s;
    assign axis_m_tdata  = m_tdata_r;
    assign axis_m_tkeep  = m_tkeep_r;
    assign axis_m_tvalid = m_tvalid_r;
    assign axis_m_tlast  = m_tlast_r;
    assign axis_s_sel    = grant_r;
    assign arb_busy      = (state_r == ST_PKT);

endmodule

// File: tb/tb_aurora_axi_tx_arb.sv
// Scoreboard bench for aurora_axi_tx_arb: packets queued per source, expected beats
// queued in the order the round-robin arbiter must emit them.
module tb_aurora_axi_tx_arb;

    localparam int ETH = 4;
    typedef logic [39:0] beat_t;  // {bubble[2:0], last, keep[3:0], data[31:0]}

    logic           clk;
    logic           rstn;
    logic [ETH-1:0] axis_s_tready;
    logic [ETH*32-1:0] axis_s_tdata;
    logic [ETH*4-1:0]  axis_s_tkeep;
    logic [ETH-1:0] axis_s_tvalid;
    logic [ETH-1:0] axis_s_tlast;
    logic           axis_m_tready;
    logic [31:0]    axis_m_tdata;
    logic [3:0]     axis_m_tkeep;
    logic           axis_m_tvalid;
    logic           axis_m_tlast;
    logic [2:0]     axis_s_sel;
    logic           arb_busy;

    aurora_axi_tx_arb #(.ETHCOUNT(ETH), .SIM(0)) dut (
        .clk(clk), .rstn(rstn),
        .axis_s_tready(axis_s_tready), .axis_s_tdata(axis_s_tdata),
        .axis_s_tkeep(axis_s_tkeep), .axis_s_tvalid(axis_s_tvalid),
        .axis_s_tlast(axis_s_tlast), .axis_m_tready(axis_m_tready),
        .axis_m_tdata(axis_m_tdata), .axis_m_tkeep(axis_m_tkeep),
        .axis_m_tvalid(axis_m_tvalid), .axis_m_tlast(axis_m_tlast),
        .axis_s_sel(axis_s_sel), .arb_busy(arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    beat_t       src_q [ETH][$];
    logic [36:0] exp_q [$];
    int          grant_exp [$];
    logic        rdy_pat [$];

    int   cyc = 0;
    logic hs_src [ETH];
    logic prev_busy = 1'b0;
    logic [2:0] prev_sel = 3'd0;
    logic prev_stall = 1'b0;
    logic [36:0] prev_out = 37'd0;
    logic chk_gap = 1'b0;
    logic have_last_hs = 1'b0;
    logic prev_out_last = 1'b0;
    int   last_hs_cyc = 0;
    logic lat_arm = 1'b0;
    int   lat_start = -1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Queue one packet on a source and its expected output beats on the scoreboard.
    task automatic add_pkt(input int src, input int nbeats, input logic [31:0] base,
                           input int bub_at);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b[31:0]  = base + 32'(k);
            b[35:32] = 4'(k + src);
            b[36]    = (k == nbeats - 1);
            b[39:37] = (k == bub_at) ? 3'd5 : 3'd0;
            src_q[src].push_back(b);
            exp_q.push_back(b[36:0]);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk_eq(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_m"}, {axis_m_tdata, axis_m_tkeep, axis_m_tvalid, axis_m_tlast}, 64'd0);
        chk_eq({tag, "_ctl"}, {axis_s_sel, arb_busy, axis_s_tready}, 64'd0);
    endtask

    // Monitor (negedge) and source/sink driver (just after posedge).
    initial begin : mon_drv
        logic [36:0] e;
        beat_t h;
        axis_s_tdata  = '0;
        axis_s_tkeep  = '0;
        axis_s_tvalid = '0;
        axis_s_tlast  = '0;
        axis_m_tready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (axis_m_tvalid && axis_m_tready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_beat", {axis_m_tlast, axis_m_tkeep, axis_m_tdata}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("beat", {axis_m_tlast, axis_m_tkeep, axis_m_tdata}, e);
                end
                if (lat_arm) begin
                    chk_eq("first_beat_latency", 64'(cyc - lat_start), 64'd2);
                    lat_arm = 1'b0;
                end
                if (chk_gap && have_last_hs)
                    chk_eq("beat_spacing", 64'(cyc - last_hs_cyc), prev_out_last ? 64'd2 : 64'd1);
                last_hs_cyc   = cyc;
                prev_out_last = axis_m_tlast;
                have_last_hs  = 1'b1;
            end
            if (prev_stall)
                chk_eq("stall_hold", {axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata},
                       {1'b1, prev_out});
            if (axis_m_tvalid && !axis_m_tready)
                chk_eq("stall_src_ready", 64'(axis_s_tready), 64'd0);
            if (arb_busy)
                chk_eq("ready_only_grant", 64'(axis_s_tready & ~(4'b0001 << axis_s_sel)), 64'd0);
            if (arb_busy && prev_busy)
                chk_eq("grant_held", 64'(axis_s_sel), 64'(prev_sel));
            if (arb_busy && !prev_busy && grant_exp.size() > 0)
                chk_eq("grant_order", 64'(axis_s_sel), 64'(grant_exp.pop_front()));
            if (lat_arm && lat_start < 0 && axis_s_tvalid[2])
                lat_start = cyc;
            for (int i = 0; i < ETH; i++)
                hs_src[i] = axis_s_tvalid[i] && axis_s_tready[i];
            prev_busy  = arb_busy;
            prev_sel   = axis_s_sel;
            prev_stall = axis_m_tvalid && !axis_m_tready;
            prev_out   = {axis_m_tlast, axis_m_tkeep, axis_m_tdata};

            @(posedge clk);
            #1;
            for (int i = 0; i < ETH; i++) begin
                if (hs_src[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
                axis_s_tvalid[i] = 1'b0;
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    if (h[39:37] != 3'd0) begin
                        h[39:37] = h[39:37] - 3'd1;
                        src_q[i][0] = h;
                    end else begin
                        axis_s_tvalid[i] = 1'b1;
                    end
                    axis_s_tdata[i*32 +: 32] = h[31:0];
                    axis_s_tkeep[i*4 +: 4]   = h[35:32];
                    axis_s_tlast[i]          = h[36];
                end
            end
            if (axis_m_tvalid && rdy_pat.size() > 0)
                axis_m_tready = rdy_pat.pop_front();
            else
                axis_m_tready = 1'b1;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : main
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        step();

        // Single 3-beat packet on source 2; ptr ends at 3.
        lat_start = -1;
        lat_arm   = 1'b1;
        grant_exp.push_back(2);
        add_pkt(2, 3, 32'hA0, -1);
        drain("single_drain", 40);
        chk_eq("latency_seen", 64'(lat_arm), 64'd0);

        // Wrap-around from ptr = 3: source 3 before source 1.
        grant_exp.push_back(3);
        grant_exp.push_back(1);
        add_pkt(3, 2, 32'h3300_0000, -1);
        add_pkt(1, 2, 32'h1100_0000, -1);
        drain("wrap_drain", 60);

        // Backpressure on a 4-beat packet from source 2.
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        grant_exp.push_back(2);
        add_pkt(2, 4, 32'h2200_0000, -1);
        drain("bp_drain", 60);

        // Five-cycle bubble on source 3 while source 0 waits.
        grant_exp.push_back(3);
        grant_exp.push_back(0);
        add_pkt(3, 4, 32'h3300_1000, 2);
        add_pkt(0, 2, 32'h0000_1000, -1);
        drain("bubble_drain", 80);

        // Reset during beat 2 of a source 1 packet.
        grant_exp.push_back(1);
        add_pkt(1, 4, 32'h1100_2000, -1);
        begin
            int n = 0;
            while (exp_q.size() > 2 && n < 40) begin
                step();
                n++;
            end
            chk_eq("pre_reset_beats", 64'(exp_q.size()), 64'd2);
        end
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 check_reset_outputs("midpkt_reset");
        for (int i = 0; i < ETH; i++) src_q[i].delete();
        exp_q.delete();
        grant_exp.delete();
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        step();

        // All sources stream 2-beat packets; order must restart at source 0.
        chk_gap      = 1'b1;
        have_last_hs = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < ETH; s++) begin
                grant_exp.push_back(s);
                add_pkt(s, 2, 32'h5000_0000 + 32'(s << 16) + 32'(p << 8), -1);
            end
        end
        drain("rr_drain", 120);
        chk_gap = 1'b0;
        chk_eq("rr_grants_used", 64'(grant_exp.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
